// File: rtl/mig_app_responder_if.sv
// MIG DDR2 user-application interface bundle.
//   master : application side (drives commands and write data, sees flags/read data)
//   slave  : responder side
// Signals:
//   app_af_wren/app_af_cmd/app_af_addr             address/command FIFO push
//   app_wdf_wren/app_wdf_data/app_wdf_mask_data    write-data FIFO push (mask 1 = keep byte)
//   app_af_afull/app_wdf_afull                     almost-full flags
//   rd_data_valid/rd_data_fifo_out                 read beats
//   phy_init_done, ovf_err, cmd_err                status
interface mig_app_responder_if #(
  parameter int unsigned APPDATA_WIDTH    = 128,
  parameter int unsigned INPUT_ADDR_WIDTH = 31
);
  logic                          app_af_wren;
  logic [2:0]                    app_af_cmd;
  logic [INPUT_ADDR_WIDTH-1:0]   app_af_addr;
  logic                          app_wdf_wren;
  logic [APPDATA_WIDTH-1:0]      app_wdf_data;
  logic [APPDATA_WIDTH/8-1:0]    app_wdf_mask_data;
  logic                          app_af_afull;
  logic                          app_wdf_afull;
  logic                          rd_data_valid;
  logic [APPDATA_WIDTH-1:0]      rd_data_fifo_out;
  logic                          phy_init_done;
  logic                          ovf_err;
  logic                          cmd_err;

  modport master (
    output app_af_wren, app_af_cmd, app_af_addr,
    output app_wdf_wren, app_wdf_data, app_wdf_mask_data,
    input  app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    input  phy_init_done, ovf_err, cmd_err
  );

  modport slave (
    input  app_af_wren, app_af_cmd, app_af_addr,
    input  app_wdf_wren, app_wdf_data, app_wdf_mask_data,
    output app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    output phy_init_done, ovf_err, cmd_err
  );
endinterface

// File: rtl/mig_app_responder.sv
// Cycle-level responder for the DDR2 MIG user-application interface, backed by an
// internal APPDATA_WIDTH x 2**MEM_AW array. Bursts are two beats; word index is
// {app_af_addr[MEM_AW:2], beat}.
// Ports:
//   clk        single clock
//   sys_rst_n  synchronous active-low reset (array contents survive it)
//   app        mig_app_responder_if.slave (command/data FIFOs in, read beats/status out)
// Optional feature: define MIG_RESP_REFRESH_EN to add periodic refresh (state REF,
// REFI_CYCLES interval, RFC_CYCLES duration).
module mig_app_responder #(
  parameter int unsigned APPDATA_WIDTH    = 128,
  parameter int unsigned INPUT_ADDR_WIDTH = 31,
  parameter int unsigned MEM_AW           = 10,
  parameter int unsigned AF_DEPTH         = 4,
  parameter int unsigned WDF_DEPTH        = 8,
  parameter int unsigned READ_LAT         = 4,
  parameter int unsigned INIT_CYCLES      = 16,
  parameter int unsigned REFI_CYCLES      = 1000,
  parameter int unsigned RFC_CYCLES       = 20
) (
  input logic               clk,
  input logic               sys_rst_n,
  mig_app_responder_if.slave app
);

  localparam int unsigned MaskW = APPDATA_WIDTH / 8;
  localparam int unsigned RowW  = MEM_AW - 1;
  localparam int unsigned AfPw  = $clog2(AF_DEPTH);
  localparam int unsigned AfCw  = AfPw + 1;
  localparam int unsigned WdfPw = $clog2(WDF_DEPTH);
  localparam int unsigned WdfCw = WdfPw + 1;
  localparam logic [2:0]  CmdWr = 3'b000;
  localparam logic [2:0]  CmdRd = 3'b001;

`ifdef MIG_RESP_REFRESH_EN
  typedef enum logic [2:0] {StInit, StIdle, StWr0, StWr1, StRdw, StRd0, StRd1, StRef} state_e;
`else
  typedef enum logic [2:0] {StInit, StIdle, StWr0, StWr1, StRdw, StRd0, StRd1} state_e;
`endif

  state_e                    state_q;
  logic [31:0]               cnt_q;
  logic [RowW-1:0]           row_q;
  logic                      init_done_q, rd_valid_q, cmd_err_q, ovf_err_q;
  logic                      af_afull_q, wdf_afull_q;
  logic [APPDATA_WIDTH-1:0]  rd_data_q;
  logic [APPDATA_WIDTH-1:0]  mem_q [2**MEM_AW];

  // Address/command FIFO: only the command and the row bits are kept.
  logic [2:0]                af_cmd_mem [AF_DEPTH];
  logic [RowW-1:0]           af_row_mem [AF_DEPTH];
  logic [AfPw-1:0]           af_wp_q, af_rp_q;
  logic [AfCw-1:0]           af_cnt_q;
  // Write-data FIFO.
  logic [APPDATA_WIDTH-1:0]  wdf_data_mem [WDF_DEPTH];
  logic [MaskW-1:0]          wdf_mask_mem [WDF_DEPTH];
  logic [WdfPw-1:0]          wdf_wp_q, wdf_rp_q;
  logic [WdfCw-1:0]          wdf_cnt_q;

  logic af_push_req, af_full, af_empty, af_push, af_pop, af_ovf;
  logic wdf_push_req, wdf_full, wdf_push, wdf_pop, wdf_ovf;
  logic go_ref, idle_take, go_wr, go_rd, go_bad;
  logic [2:0]      af_head_cmd;
  logic [RowW-1:0] af_head_row;
  logic [MEM_AW-1:0] wr_idx;

  logic unused_addr;
  assign unused_addr = ^{app.app_af_addr[INPUT_ADDR_WIDTH-1:MEM_AW+1], app.app_af_addr[1:0]};

`ifdef MIG_RESP_REFRESH_EN
  logic [31:0] refi_q;
  logic        ref_pend_q;

  // Interval counter parks at expiry until the engine reaches IDLE and enters REF.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      refi_q     <= '0;
      ref_pend_q <= 1'b0;
    end else if (state_q == StIdle && ref_pend_q) begin
      refi_q     <= '0;
      ref_pend_q <= 1'b0;
    end else if (init_done_q && !ref_pend_q) begin
      if (refi_q == REFI_CYCLES - 1) ref_pend_q <= 1'b1;
      else                           refi_q     <= refi_q + 32'd1;
    end
  end
  assign go_ref = ref_pend_q;
`else
  logic [31:0] unused_ref;
  assign unused_ref = REFI_CYCLES ^ RFC_CYCLES;
  assign go_ref     = 1'b0;
`endif

  always_comb begin
    af_head_cmd  = af_cmd_mem[af_rp_q];
    af_head_row  = af_row_mem[af_rp_q];
    af_empty     = (af_cnt_q == '0);
    af_full      = (af_cnt_q == AfCw'(AF_DEPTH));
    wdf_full     = (wdf_cnt_q == WdfCw'(WDF_DEPTH));
    idle_take    = (state_q == StIdle) && !af_empty && !go_ref;
    go_wr        = idle_take && (af_head_cmd == CmdWr) && (wdf_cnt_q >= WdfCw'(2));
    go_rd        = idle_take && (af_head_cmd == CmdRd);
    go_bad       = idle_take && (af_head_cmd != CmdWr) && (af_head_cmd != CmdRd);
    // Write commands leave the FIFO in WR0, reads and bad commands straight from IDLE.
    af_pop       = go_rd || go_bad || (state_q == StWr0);
    wdf_pop      = (state_q == StWr0) || (state_q == StWr1);
    af_push_req  = app.app_af_wren && init_done_q;
    wdf_push_req = app.app_wdf_wren && init_done_q;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still legal.
    af_push      = af_push_req && (!af_full || af_pop);
    af_ovf       = af_push_req && af_full && !af_pop;
    wdf_push     = wdf_push_req && (!wdf_full || wdf_pop);
    wdf_ovf      = wdf_push_req && wdf_full && !wdf_pop;
    wr_idx       = {row_q, state_q == StWr1};
  end

  always_ff @(posedge clk) begin
    if (af_push) begin
      af_cmd_mem[af_wp_q] <= app.app_af_cmd;
      af_row_mem[af_wp_q] <= app.app_af_addr[MEM_AW:2];
    end
    if (wdf_push) begin
      wdf_data_mem[wdf_wp_q] <= app.app_wdf_data;
      wdf_mask_mem[wdf_wp_q] <= app.app_wdf_mask_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      af_wp_q     <= '0;
      af_rp_q     <= '0;
      af_cnt_q    <= '0;
      wdf_wp_q    <= '0;
      wdf_rp_q    <= '0;
      wdf_cnt_q   <= '0;
      af_afull_q  <= 1'b0;
      wdf_afull_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      if (af_push) af_wp_q <= af_wp_q + AfPw'(1);
      if (af_pop)  af_rp_q <= af_rp_q + AfPw'(1);
      if (af_push && !af_pop)      af_cnt_q <= af_cnt_q + AfCw'(1);
      else if (!af_push && af_pop) af_cnt_q <= af_cnt_q - AfCw'(1);
      if (wdf_push) wdf_wp_q <= wdf_wp_q + WdfPw'(1);
      if (wdf_pop)  wdf_rp_q <= wdf_rp_q + WdfPw'(1);
      if (wdf_push && !wdf_pop)      wdf_cnt_q <= wdf_cnt_q + WdfCw'(1);
      else if (!wdf_push && wdf_pop) wdf_cnt_q <= wdf_cnt_q - WdfCw'(1);
      // Flags follow the occupancy of the previous cycle.
      af_afull_q  <= (af_cnt_q >= AfCw'(AF_DEPTH - 1));
      wdf_afull_q <= (wdf_cnt_q >= WdfCw'(WDF_DEPTH - 2));
      ovf_err_q   <= ovf_err_q | af_ovf | wdf_ovf;
    end
  end

  // Array has no reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (sys_rst_n && wdf_pop) begin
      for (int b = 0; b < int'(MaskW); b++) begin
        if (!wdf_mask_mem[wdf_rp_q][b]) mem_q[wr_idx][b*8 +: 8] <= wdf_data_mem[wdf_rp_q][b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      row_q       <= '0;
      init_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        StInit: begin
          if (cnt_q == INIT_CYCLES) begin
            state_q     <= StIdle;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StIdle: begin
          cnt_q <= '0;
`ifdef MIG_RESP_REFRESH_EN
          if (go_ref) state_q <= StRef;
          else
`endif
          if (go_wr) begin
            state_q <= StWr0;
            row_q   <= af_head_row;
          end else if (go_rd) begin
            state_q <= StRdw;
            row_q   <= af_head_row;
          end else if (go_bad) begin
            cmd_err_q <= 1'b1;
          end
        end
        StWr0: state_q <= StWr1;
        StWr1: state_q <= StIdle;
        StRdw: begin
          if (cnt_q == READ_LAT - 1) state_q <= StRd0;
          else                       cnt_q   <= cnt_q + 32'd1;
        end
        StRd0: begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= mem_q[{row_q, 1'b0}];
          state_q    <= StRd1;
        end
        StRd1: begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= mem_q[{row_q, 1'b1}];
          state_q    <= StIdle;
        end
`ifdef MIG_RESP_REFRESH_EN
        StRef: begin
          if (cnt_q == RFC_CYCLES - 1) state_q <= StIdle;
          else                         cnt_q   <= cnt_q + 32'd1;
        end
`endif
        default: state_q <= StInit;
      endcase
    end
  end

  assign app.app_af_afull     = af_afull_q;
  assign app.app_wdf_afull    = wdf_afull_q;
  assign app.rd_data_valid    = rd_valid_q;
  assign app.rd_data_fifo_out = rd_data_q;
  assign app.phy_init_done    = init_done_q;
  assign app.ovf_err          = ovf_err_q;
  assign app.cmd_err          = cmd_err_q;

endmodule
